// File: rtl/dbsr_right_pipe.sv
// Pipelined right barrel shifter with sticky generation: stage k shifts by 2^k when b[k] is set.
// Valid/ready flow control per stage; empty slots are filled even while the output is stalled.
module dbsr_right_pipe #(
  parameter int unsigned N     = 8,
  parameter int unsigned Bs    = ($clog2(N) < 1) ? 1 : $clog2(N),
  parameter bit          ARITH = 1'b0,
  parameter int unsigned TW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [Bs-1:0] b,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  c,
  output logic          sticky,
  output logic [TW-1:0] out_tag
);

  localparam logic [N-1:0] Ones = '1;

  // Per-stage registered state
  logic [Bs-1:0] vld_q;
  logic [Bs-1:0] stk_q;
  logic          fill_q [Bs];
  logic [N-1:0]  dat_q  [Bs];
  logic [TW-1:0] tag_q  [Bs];
  logic [Bs-1:0] rem_q  [Bs];

  // Values presented to each stage by its upstream neighbour
  logic [Bs-1:0] up_vld;
  logic [Bs-1:0] up_stk;
  logic          up_fill [Bs];
  logic [N-1:0]  up_dat  [Bs];
  logic [TW-1:0] up_tag  [Bs];
  logic [Bs-1:0] up_rem  [Bs];

  logic [N-1:0]  dat_d   [Bs];
  logic [Bs-1:0] rem_d   [Bs];
  logic [Bs-1:0] stk_d;
  logic [Bs-1:0] sh_bit;

  logic [Bs-1:0] rdy_dn;
  logic [Bs-1:0] en;

  // rdy_dn[k]: the slot below stage k is empty or draining this cycle
  always_comb begin
    rdy_dn = '0;
    rdy_dn[Bs-1] = out_ready;
    for (int k = int'(Bs) - 2; k >= 0; k--) begin
      rdy_dn[k] = ~vld_q[k+1] | rdy_dn[k+1];
    end
    en = ~vld_q | rdy_dn;
  end

  assign in_ready = en[0];

  for (genvar k = 0; k < Bs; k++) begin : g_stg
    localparam int unsigned Sh = 32'd1 << k;

    if (k == 0) begin : g_head
      assign up_vld[k]  = in_valid;
      assign up_stk[k]  = 1'b0;
      assign up_fill[k] = ARITH & a[N-1];
      assign up_dat[k]  = a;
      assign up_tag[k]  = in_tag;
      assign up_rem[k]  = b;
    end else begin : g_link
      assign up_vld[k]  = vld_q[k-1];
      assign up_stk[k]  = stk_q[k-1];
      assign up_fill[k] = fill_q[k-1];
      assign up_dat[k]  = dat_q[k-1];
      assign up_tag[k]  = tag_q[k-1];
      assign up_rem[k]  = rem_q[k-1];
    end

    // rem holds the not-yet-applied shift bits, LSB is this stage's bit
    assign sh_bit[k] = up_rem[k][0];
    assign rem_d[k]  = up_rem[k] >> 1;

    // Shifts of 2^k >= N empty the word: data becomes all fill, everything goes to sticky
    assign dat_d[k] = sh_bit[k] ?
                      ((up_dat[k] >> Sh) | ({N{up_fill[k]}} & ~(Ones >> Sh))) : up_dat[k];
    assign stk_d[k] = up_stk[k] | (sh_bit[k] & (|(up_dat[k] & ~(Ones << Sh))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      stk_q <= '0;
      for (int k = 0; k < int'(Bs); k++) begin
        fill_q[k] <= 1'b0;
        dat_q[k]  <= '0;
        tag_q[k]  <= '0;
        rem_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < int'(Bs); k++) begin
        if (en[k]) begin
          vld_q[k] <= up_vld[k];
        end
        if (en[k] && up_vld[k]) begin
          stk_q[k]  <= stk_d[k];
          fill_q[k] <= up_fill[k];
          dat_q[k]  <= dat_d[k];
          tag_q[k]  <= up_tag[k];
          rem_q[k]  <= rem_d[k];
        end
      end
    end
  end

  assign out_valid = vld_q[Bs-1];
  assign c         = dat_q[Bs-1];
  assign sticky    = stk_q[Bs-1];
  assign out_tag   = tag_q[Bs-1];

endmodule

// File: tb/tb_dbsr_right_pipe.sv
// Randomized and directed bench for dbsr_right_pipe; a logical and an arithmetic instance
// run in lockstep against a queue-based reference model.
module tb_dbsr_right_pipe;

  localparam int N  = 8;
  localparam int BS = 3;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [N-1:0]  a;
  logic [BS-1:0] b;
  logic [TW-1:0] in_tag;

  logic          in_ready, out_valid, sticky;
  logic [N-1:0]  c;
  logic [TW-1:0] out_tag;
  logic          in_ready_s, out_valid_s, sticky_s;
  logic [N-1:0]  c_s;
  logic [TW-1:0] out_tag_s;

  always #5 clk = ~clk;

  dbsr_right_pipe #(.N(N), .Bs(BS), .ARITH(1'b0), .TW(TW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .c(c), .sticky(sticky),
    .out_tag(out_tag)
  );

  dbsr_right_pipe #(.N(N), .Bs(BS), .ARITH(1'b1), .TW(TW)) u_dut_arith (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(out_valid_s), .out_ready(out_ready), .c(c_s),
    .sticky(sticky_s), .out_tag(out_tag_s)
  );

  typedef struct packed {
    logic [N-1:0]  cl;
    logic          sl;
    logic [N-1:0]  ca;
    logic          sa;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_acc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  // Reference: integer shifts; sticky is any set bit among those pushed past the LSB
  function automatic exp_t model(input logic [N-1:0] x, input int sh, input logic [TW-1:0] t);
    exp_t e;
    int   sv;
    e.cl = N'(int'(x) >> sh);
    sv   = int'($signed(x));
    e.ca = N'(sv >>> sh);
    e.sl = (sh >= N) ? (x != 0) : ((int'(x) & ((1 << sh) - 1)) != 0);
    e.sa = e.sl;
    e.tag = t;
    return e;
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    #1;
    chk("in_ready", in_ready, (sb.size() < BS) || out_ready);
    chk("in_ready_arith", in_ready_s, (sb.size() < BS) || out_ready);
    if (sb.size() == 0) begin
      chk("spurious_out", out_valid, 1'b0);
      chk("spurious_out_arith", out_valid_s, 1'b0);
    end else begin
      if (out_valid) begin
        chk("c", c, sb[0].cl);
        chk("sticky", sticky, sb[0].sl);
        chk("out_tag", out_tag, sb[0].tag);
      end
      if (out_valid_s) begin
        chk("c_arith", c_s, sb[0].ca);
        chk("sticky_arith", sticky_s, sb[0].sa);
        chk("out_tag_arith", out_tag_s, sb[0].tag);
      end
    end
    if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
    if (in_valid && in_ready) begin
      sb.push_back(model(a, int'(b), in_tag));
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic send_lat(input logic [N-1:0] x, input logic [BS-1:0] s, input logic [TW-1:0] t,
                          input logic [N-1:0] ec, input logic es, input logic [N-1:0] eca);
    int lat;
    in_valid  = 1'b1;
    a         = x;
    b         = s;
    in_tag    = t;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = N'($urandom);
    b        = BS'($urandom);
    in_tag   = TW'($urandom);
    lat      = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency", lat, 3);
    chk("dir_c", c, ec);
    chk("dir_sticky", sticky, es);
    chk("dir_tag", out_tag, t);
    chk("dir_c_arith", c_s, eca);
    chk("dir_sticky_arith", sticky_s, es);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    exp_t e;
    logic [N-1:0] x;
    logic [BS-1:0] s;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_c", c, '0);
    chk("rst_sticky", sticky, 1'b0);
    chk("rst_out_tag", out_tag, '0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Directed vectors
    send_lat(8'b1011_0110, 3'd3, 4'd5, 8'b0001_0110, 1'b1, 8'b1111_0110);
    send_lat(8'h80, 3'd7, 4'd9, 8'h01, 1'b0, 8'hFF);
    send_lat(8'hA5, 3'd0, 4'd2, 8'hA5, 1'b0, 8'hA5);

    // Back-to-back stream: one result per cycle
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; a = N'($urandom); b = BS'($urandom); in_tag = TW'(i);
      tick();
      n++;
    end
    in_valid = 1'b0;
    while (sb.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    chk("stream_cycles", n, 16 + BS);

    // Backpressure: capacity is BS, then drain on consecutive cycles
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = N'($urandom); b = BS'($urandom); in_tag = TW'($urandom);
      tick();
    end
    chk("bp_accepted", n_acc, BS);
    chk("bp_in_ready", in_ready, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("bp_drain", n, BS);

    // Bubble collapse: second word must not sit behind an empty slot
    out_ready = 1'b0;
    in_valid = 1'b1; a = N'($urandom); b = BS'($urandom); in_tag = 4'd1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1; a = N'($urandom); b = BS'($urandom); in_tag = 4'd2;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("bubble_drain", n, 2);

    // Reset with two words in flight
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = N'($urandom); b = BS'($urandom); in_tag = TW'(i + 7);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_c", c, '0);
    chk("midrst_sticky", sticky, 1'b0);
    chk("midrst_out_tag", out_tag, '0);
    chk("midrst_out_valid_arith", out_valid_s, 1'b0);
    sb.delete();
    rst = 1'b0;
    repeat (5) tick();
    x = N'($urandom);
    s = BS'($urandom);
    e = model(x, int'(s), 4'd11);
    send_lat(x, s, 4'd11, e.cl, e.sl, e.ca);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 10) < 7;
      a         = N'($urandom);
      b         = BS'($urandom);
      in_tag    = TW'($urandom);
      out_ready = ($urandom % 10) < 6;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("final_drain_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
